nibble_add_scheduler: RTL and testbench
=======================================

# nibble_add_scheduler

Shares a single 4-bit ripple adder slice between two requesters and sequences multi-nibble additions through it, one nibble per clock, with the carry held in a register between passes. It sits between two operand producers and one result consumer. It replaces two full-width adders with one `multi_bit`-style 4-bit datapath plus control. Arbitration is round-robin, and both the request and response sides use valid/ready handshakes.

## Interface
- `WORDS`, default 4: nibbles per operand. Operand width is `W = 4*WORDS`. Legal range is 1..16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_a`, `req0_b` in W: operands for requester 0.
- `req0_cin` in 1: carry-in for requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a result is presented.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_id` out 1: index of the requester that owns the result.
- `rsp_sum` out W: `(a+b+cin) mod 2^W`.
- `rsp_cout` out 1: bit W of `a+b+cin`.
- `busy` out 1: high in RUN or RESP.

## Operation
- State machine has three states: IDLE, RUN, RESP.
- **IDLE, arbitration:**
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, grant the requester that is not `last_grant`.
  - `reqN_ready` is combinational: high only in IDLE, only for the granted requester, and never during `rst`.
- **On acceptance (valid & ready at an edge):**
  - Capture a, b and cin into internal registers.
  - Load the carry register with cin and set the nibble index to 0.
  - Set `last_grant` to N and go to RUN.
- **RUN:**
  - Each cycle, the adder slice computes `a[4i+3:4i] + b[4i+3:4i] + carry`.
  - The 4-bit result is written to `sum[4i+3:4i]` and the carry register is updated.
  - The index increments each cycle.
  - After the edge that processes index `WORDS-1`, go to RESP.
- **RESP:**
  - Drive `rsp_valid=1` with `rsp_sum` = the full sum register, `rsp_cout` = the final carry, and `rsp_id` = the granted requester.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- **Output stability:**
  - `rsp_*` values are stable while `rsp_valid & !rsp_ready`.
  - After the handshake, `rsp_sum`, `rsp_cout` and `rsp_id` keep their last values until the next result.
- No request is accepted outside IDLE. A `reqN_valid` that drops before it is granted is simply not served; no error is raised.
- Operand inputs are sampled only at the acceptance edge. Later changes have no effect on the operation in flight.
- Arithmetic is modulo `2^W`. The carry propagates across nibbles exactly as in a full-width add. No signed interpretation.

## Timing
- **Reset:** state IDLE; `rsp_valid=0`, `busy=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`; `req0_ready` and `req1_ready` are 0 while `rst` is high; `last_grant=1`, so requester 0 wins the first contention.
- **Reset mid-operation:** reset during RUN or RESP aborts the operation. No response is produced and the aborted requester is not re-served. `rst` overrides every other input in the same cycle.
- **Latency:**
  - Acceptance edge is E0.
  - `busy` rises after E0.
  - `rsp_valid` rises after edge E0+WORDS (WORDS RUN cycles).
  - Response handshake at edge Er makes the block IDLE after Er, so `reqN_ready` can assert in the cycle after Er.
- **Throughput:** with `rsp_ready` tied high, one operation per `WORDS+2` cycles. With both requesters continuously valid, grants alternate 0,1,0,1.
- **`WORDS=1`:** RUN lasts exactly one cycle.

## Test plan
- **Reset:** assert `rst` 2 cycles with both valids high. Require `req*_ready=0`, `rsp_valid=0`, `busy=0`, `rsp_sum=0`. The first grant after release goes to requester 0.
- **Basic add:** `WORDS=4`, req0 with a=16'h1234, b=16'h4321, cin=0. Require `rsp_sum=16'h5555`, `rsp_cout=0`, `rsp_id=0`, and `rsp_valid` high exactly 4 cycles after the acceptance edge.
- **Full carry chain:** req1 with a=16'hFFFF, b=16'h0000, cin=1. Require `rsp_sum=16'h0000`, `rsp_cout=1`, `rsp_id=1`. Also run a=16'h8000, b=16'h8000, cin=0, requiring sum 16'h0000 and cout 1.
- **Fairness:** both valids held high for 8 operations with `rsp_ready=1`. Require `rsp_id` sequence 0,1,0,1,0,1,0,1 and 6 cycles per operation.
- **Backpressure:** `rsp_ready=0` for 5 cycles in RESP. Require `rsp_*` unchanged, `busy=1`, both `req*_ready=0`. Raise `rsp_ready` and require IDLE in the next cycle.
- **Reset mid-RUN:** assert `rst` at the 2nd RUN cycle. Require no `rsp_valid`, `busy=0` after the edge, and the next request computed correctly.

Source files
------------

// File: rtl/nibble_add_scheduler.sv
// Two-requester round-robin front end for a shared 4-bit adder slice.
// Each accepted addition is processed one nibble per clock, with the carry held between passes.
module nibble_add_scheduler #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [4*WORDS-1:0]   req0_a,
   input  logic [4*WORDS-1:0]   req0_b,
   input  logic                 req0_cin,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [4*WORDS-1:0]   req1_a,
   input  logic [4*WORDS-1:0]   req1_b,
   input  logic                 req1_cin,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [4*WORDS-1:0]   rsp_sum,
   output logic                 rsp_cout,
   output logic                 busy
);

   localparam int W  = 4 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [W-1:0]  sum_next;
   logic          carry_q;
   logic [IW-1:0] idx;
   logic          last_grant;
   logic          cur_id;
   logic          grant0;
   logic          grant1;
   logic [IW+1:0] bit_base;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    nib_sum;

   // On contention, the requester that did not win last time goes first.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = ~rst & (state == IDLE) & grant0;
   assign req1_ready = ~rst & (state == IDLE) & grant1;

   always_comb begin
      bit_base = {idx, 2'b00};
      a_nib    = a_q[bit_base +: 4];
      b_nib    = b_q[bit_base +: 4];
      nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      sum_next = sum_q;
      sum_next[bit_base +: 4] = nib_sum[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         busy       <= 1'b0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         idx        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready | req1_ready) begin
                  a_q        <= grant1 ? req1_a : req0_a;
                  b_q        <= grant1 ? req1_b : req0_b;
                  carry_q    <= grant1 ? req1_cin : req0_cin;
                  cur_id     <= grant1;
                  last_grant <= grant1;
                  idx        <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_next;
               carry_q <= nib_sum[4];
               idx     <= idx + 1'b1;
               // Response registers load from the combinational next-sum so the
               // final nibble is visible in the same cycle rsp_valid rises.
               if (idx == LAST_IDX) begin
                  rsp_sum   <= sum_next;
                  rsp_cout  <= nib_sum[4];
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Directed-plus-random bench for nibble_add_scheduler; results are compared against
// full-width reference arithmetic and a round-robin grant model.
module tb_nibble_add_scheduler;

   localparam int WORDS = 4;
   localparam int W     = 4 * WORDS;

   logic         clk;
   logic         rst;
   logic         req0_valid, req0_ready, req0_cin;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [W-1:0] rsp_sum;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   logic model_last = 1'b1;
   time acc_times[$];

   nibble_add_scheduler #(.WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_operands();
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
   endtask

   // Called at posedge+1 with the block idle; returns after the response handshake.
   task automatic do_op(input logic v0, input logic v1, input bit hold, input int stall, output int gid);
      int n;
      int exp_id;
      logic [W:0] exp;
      gid = -1;
      req0_valid = v0;
      req1_valid = v1;
      rsp_ready  = (stall == 0);
      #1;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      if (!(req0_ready | req1_ready)) begin
         check("grant_timeout", 0, 1);
         return;
      end
      check("single_ready", 64'(req0_ready & req1_ready), 0);
      gid    = req1_ready ? 1 : 0;
      exp_id = (v0 && v1) ? (model_last ? 0 : 1) : (v1 ? 1 : 0);
      check("grant_id", 64'(gid), 64'(exp_id));
      model_last = gid[0];
      exp = gid[0] ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
      @(posedge clk);
      acc_times.push_back($time);
      #1;
      if (!hold) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      randomize_operands();
      check("busy_after_accept", 64'(busy), 1);
      check("no_early_rsp", 64'(rsp_valid), 0);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), WORDS);
      if (!rsp_valid) return;
      check("rsp_sum", 64'(rsp_sum), 64'(exp[W-1:0]));
      check("rsp_cout", 64'(rsp_cout), 64'(exp[W]));
      check("rsp_id", 64'(rsp_id), 64'(gid));
      for (int i = 0; i < stall; i++) begin
         check("bp_valid", 64'(rsp_valid), 1);
         check("bp_sum", 64'(rsp_sum), 64'(exp[W-1:0]));
         check("bp_cout", 64'(rsp_cout), 64'(exp[W]));
         check("bp_id", 64'(rsp_id), 64'(gid));
         check("bp_busy", 64'(busy), 1);
         check("bp_ready", 64'({req0_ready, req1_ready}), 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_hs", 64'({busy, rsp_valid}), 0);
      check("hold_sum", 64'(rsp_sum), 64'(exp[W-1:0]));
      check("hold_id", 64'(rsp_id), 64'(gid));
   endtask

   initial begin
      int gid;
      int seen;
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready = 1'b1;
      randomize_operands();

      // Reset held two cycles with both requesters asking.
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_ready", 64'({req0_ready, req1_ready}), 0);
         check("rst_valid", 64'(rsp_valid), 0);
         check("rst_busy", 64'(busy), 0);
         check("rst_sum", 64'(rsp_sum), 0);
         check("rst_cout_id", 64'({rsp_cout, rsp_id}), 0);
      end
      rst = 1'b0;
      do_op(1'b1, 1'b1, 1'b0, 0, gid);
      check("first_grant", 64'(gid), 0);

      req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
      do_op(1'b1, 1'b0, 1'b0, 0, gid);
      check("basic_sum", 64'(rsp_sum), 64'h5555);
      check("basic_cout", 64'(rsp_cout), 0);

      req0_a = 16'h8000; req0_b = 16'h8000; req0_cin = 1'b0;
      do_op(1'b1, 1'b0, 1'b0, 0, gid);
      check("msb_sum", 64'(rsp_sum), 0);
      check("msb_cout", 64'(rsp_cout), 1);

      req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1;
      do_op(1'b0, 1'b1, 1'b0, 0, gid);
      check("chain_sum", 64'(rsp_sum), 0);
      check("chain_cout", 64'(rsp_cout), 1);
      check("chain_id", 64'(rsp_id), 1);

      // Fairness with both requesters continuously valid.
      acc_times.delete();
      for (int i = 0; i < 8; i++) begin
         do_op(1'b1, 1'b1, 1'b1, 0, gid);
         check("fair_seq", 64'(gid), 64'(i % 2));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 1; i < acc_times.size(); i++)
         check("fair_period", 64'(acc_times[i] - acc_times[i-1]), 64'((WORDS + 2) * 10));

      // Backpressure: five stalled cycles in RESP with both requesters waiting.
      do_op(1'b1, 1'b1, 1'b1, 5, gid);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Reset during the second RUN cycle.
      req0_valid = 1'b1;
      #1;
      check("mid_ready", 64'(req0_ready), 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = 1'b1;
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_valid", 64'(rsp_valid), 0);
      check("mid_rst_sum", 64'(rsp_sum), 0);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) seen++;
      end
      check("no_reserve", 64'(seen), 0);
      do_op(1'b0, 1'b1, 1'b0, 0, gid);

      // Random traffic mix.
      for (int i = 0; i < 12; i++) begin
         logic [1:0] v;
         v = 2'($urandom_range(1, 3));
         do_op(v[0], v[1], 1'b0, $urandom_range(0, 2), gid);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
